// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage controller for the 8-bit RISC datapath.
// Accepts one instruction at a time, drives the external ALU with registered
// operands, captures the result and flags, and writes back to a 4x8 regfile.
//
// state | meaning
// IDLE  | ready for an instruction, latch it on handshake
// OPER  | register operands and function select toward the ALU
// CAPT  | ALU inputs stable, sample result and flags
// WB    | write regfile / status, done pulses in the following cycle
module alu_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic        ld_en,
  input  logic [1:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_fs,
  output logic [2:0]  alu_sh,
  input  logic [7:0]  alu_f,
  input  logic        alu_c,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        alu_z,
  output logic [7:0]  result,
  output logic [3:0]  status,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_OPER, S_CAPT, S_WB} state_t;

  state_t state_q, state_d;

  // instr[2:0] carries no information; only [15:3] is kept
  logic [12:0]      instr_q, instr_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_fs_q, alu_fs_d;
  logic [2:0]       alu_sh_q, alu_sh_d;
  logic [7:0]       result_q, result_d;
  logic [3:0]       flg_q, flg_d;      // {C,N,V,Z} as seen from the ALU in CAPT
  logic [3:0]       status_q, status_d;
  logic             done_q, done_d;
  logic [3:0][7:0]  rf_q, rf_d;

  logic [3:0] fs;
  logic [1:0] rd, ra, rb;
  logic [2:0] sh;
  logic       wb_wr, c_upd, v_upd;
  logic       instr_unused;

  assign fs = instr_q[12:9];
  assign rd = instr_q[8:7];
  assign ra = instr_q[6:5];
  assign rb = instr_q[4:3];
  assign sh = instr_q[2:0];
  assign instr_unused = ^instr[2:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed four-cycle walk once an instruction is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (instr_valid) state_d = S_OPER;
      S_OPER: state_d = S_CAPT;
      S_CAPT: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    dbg_data    = rf_q[dbg_addr];
    alu_a       = alu_a_q;
    alu_b       = alu_b_q;
    alu_fs      = alu_fs_q;
    alu_sh      = alu_sh_q;
    result      = result_q;
    status      = status_q;
    done        = done_q;
  end

  // Datapath next values; the WB write is applied after ld so it wins a collision
  always_comb begin
    instr_d  = instr_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_fs_d = alu_fs_q;
    alu_sh_d = alu_sh_q;
    result_d = result_q;
    flg_d    = flg_q;
    status_d = status_q;
    rf_d     = rf_q;
    wb_wr    = (state_q == S_WB) && (fs != 4'd0);
    c_upd    = fs inside {4'd1, 4'd2, 4'd5, 4'd6};
    v_upd    = fs inside {4'd1, 4'd2};
    done_d   = (state_q == S_WB);

    if (state_q == S_IDLE && instr_valid) instr_d = instr[15:3];

    if (state_q == S_OPER) begin
      alu_a_d  = rf_q[ra];
      alu_b_d  = rf_q[rb];
      alu_fs_d = fs;
      alu_sh_d = sh;
    end

    if (state_q == S_CAPT) begin
      result_d = alu_f;
      flg_d    = {alu_c, alu_n, alu_v, alu_z};
    end

    if (ld_en) rf_d[ld_addr] = ld_data;

    if (wb_wr) begin
      rf_d[rd]    = result_q;
      status_d[2] = flg_q[2];
      status_d[0] = flg_q[0];
      if (c_upd) status_d[3] = flg_q[3];
      if (v_upd) status_d[1] = flg_q[1];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_fs_q <= '0;
      alu_sh_q <= '0;
      result_q <= '0;
      flg_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
      rf_q     <= '0;
    end else begin
      instr_q  <= instr_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_fs_q <= alu_fs_d;
      alu_sh_q <= alu_sh_d;
      result_q <= result_d;
      flg_q    <= flg_d;
      status_q <= status_d;
      done_q   <= done_d;
      rf_q     <= rf_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl. The bench plays the ALU: it answers with a
// hand-chosen result/flag vector only when the registered operands match what
// the instruction should have read, and with junk otherwise.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_fs;
  logic [2:0]  alu_sh;
  logic [7:0]  alu_f;
  logic        alu_c, alu_n, alu_v, alu_z;
  logic [7:0]  result;
  logic [3:0]  status;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_fs = '0;
  logic [7:0] exp_a = '0, exp_b = '0;
  logic [2:0] exp_sh = '0;
  logic [7:0] resp_f = '0;
  logic [3:0] resp_flg = '0;   // {C,N,V,Z}
  logic       match;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fs(alu_fs), .alu_sh(alu_sh), .alu_f(alu_f), .alu_c(alu_c), .alu_n(alu_n),
    .alu_v(alu_v), .alu_z(alu_z), .result(result), .status(status), .done(done)
  );

  always #5 clk = ~clk;

  assign match = (alu_fs == exp_fs) && (alu_a == exp_a) && (alu_b == exp_b) && (alu_sh == exp_sh);
  assign alu_f = match ? resp_f : 8'hEE;
  assign {alu_c, alu_n, alu_v, alu_z} = match ? resp_flg : ~resp_flg;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    check_eq(tag, {8'h00, dbg_data}, {8'h00, e});
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One full instruction with per-cycle checks; collide loads 0xAA to rd in WB
  task automatic issue(input logic [3:0] fs, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [2:0] sh, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] rf, input logic [3:0] rflg,
                       input logic [3:0] est, input bit collide);
    @(negedge clk);
    exp_fs = fs; exp_a = ea; exp_b = eb; exp_sh = sh; resp_f = rf; resp_flg = rflg;
    instr = {fs, rd, ra, rb, sh, 3'b101};
    instr_valid = 1'b1;
    check_eq("ready_idle", {15'd0, instr_ready}, 16'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    check_eq("ready_oper", {15'd0, instr_ready}, 16'd0);
    @(negedge clk);
    check_eq("alu_a", {8'd0, alu_a}, {8'd0, ea});
    check_eq("alu_b", {8'd0, alu_b}, {8'd0, eb});
    check_eq("alu_fs", {12'd0, alu_fs}, {12'd0, fs});
    check_eq("alu_sh", {13'd0, alu_sh}, {13'd0, sh});
    check_eq("done_early", {15'd0, done}, 16'd0);
    @(negedge clk);
    check_eq("result", {8'd0, result}, {8'd0, rf});
    if (collide) begin
      ld_en = 1'b1; ld_addr = rd; ld_data = 8'hAA;
    end
    @(negedge clk);
    ld_en = 1'b0;
    check_eq("done_pulse", {15'd0, done}, 16'd1);
    check_eq("ready_back", {15'd0, instr_ready}, 16'd1);
    check_eq("status", {12'd0, status}, {12'd0, est});
    @(negedge clk);
    check_eq("done_low", {15'd0, done}, 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {15'd0, instr_ready}, 16'd1);
    check_eq("rst_done", {15'd0, done}, 16'd0);
    check_eq("rst_status", {12'd0, status}, 16'd0);
    check_eq("rst_alu_a", {8'd0, alu_a}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_reg("rst_rf", i[1:0], 8'h00);

    // add: 0x7F + 0x01
    load(2'd1, 8'h7F);
    load(2'd2, 8'h01);
    issue(4'd1, 2'd3, 2'd1, 2'd2, 3'd0, 8'h7F, 8'h01, 8'h80, 4'b0110, 4'b0110, 1'b0);
    check_reg("add_r3", 2'd3, 8'h80);

    // sub to zero, rd==ra==rb
    load(2'd0, 8'h05);
    issue(4'd2, 2'd0, 2'd0, 2'd0, 3'd0, 8'h05, 8'h05, 8'h00, 4'b1011, 4'b1011, 1'b0);
    check_reg("sub_r0", 2'd0, 8'h00);

    // or keeps C and V
    issue(4'd4, 2'd2, 2'd1, 2'd1, 3'd0, 8'h7F, 8'h7F, 8'h7F, 4'b0000, 4'b1010, 1'b0);
    check_reg("or_r2", 2'd2, 8'h7F);

    // shift-left updates C, V holds
    load(2'd1, 8'h81);
    issue(4'd5, 2'd1, 2'd1, 2'd0, 3'd1, 8'h81, 8'h00, 8'h02, 4'b0000, 4'b0010, 1'b0);
    check_reg("shl_r1", 2'd1, 8'h02);

    // nop: result captured, no write, status unchanged
    issue(4'd0, 2'd1, 2'd1, 2'd1, 3'd0, 8'h02, 8'h02, 8'h55, 4'b1101, 4'b0010, 1'b0);
    check_reg("nop_r1", 2'd1, 8'h02);

    // undefined fs behaves as a non-nop: N,Z update, C,V hold
    issue(4'd13, 2'd2, 2'd1, 2'd1, 3'd0, 8'h02, 8'h02, 8'h00, 4'b1001, 4'b0011, 1'b0);
    check_reg("undef_r2", 2'd2, 8'h00);

    // back-to-back with instr_valid held high; second reads the first's writeback
    @(negedge clk);
    exp_fs = 4'd4; exp_a = 8'h02; exp_b = 8'h02; exp_sh = 3'd0;
    resp_f = 8'h02; resp_flg = 4'b1000;
    instr = {4'd4, 2'd3, 2'd1, 2'd1, 3'd0, 3'd0};
    instr_valid = 1'b1;
    check_eq("b2b_ready0", {15'd0, instr_ready}, 16'd1);
    @(negedge clk);
    instr = {4'd4, 2'd0, 2'd3, 2'd3, 3'd0, 3'd0};
    for (int k = 0; k < 3; k++) begin
      check_eq("b2b_busy", {15'd0, instr_ready}, 16'd0);
      @(negedge clk);
    end
    check_eq("b2b_ready4", {15'd0, instr_ready}, 16'd1);
    check_eq("b2b_done1", {15'd0, done}, 16'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    check_eq("b2b_accept2", {15'd0, instr_ready}, 16'd0);
    check_eq("b2b_done_lo", {15'd0, done}, 16'd0);
    repeat (3) @(negedge clk);
    check_eq("b2b_done2", {15'd0, done}, 16'd1);
    check_eq("b2b_status", {12'd0, status}, 16'b0010);
    check_reg("b2b_r3", 2'd3, 8'h02);
    check_reg("b2b_r0", 2'd0, 8'h02);

    // load to rd during WB loses to the writeback
    issue(4'd4, 2'd2, 2'd1, 2'd1, 3'd0, 8'h02, 8'h02, 8'h02, 4'b0000, 4'b0010, 1'b1);
    check_reg("coll_r2", 2'd2, 8'h02);

    // reset while in CAPT
    @(negedge clk);
    exp_fs = 4'd1; exp_a = 8'h02; exp_b = 8'h02; exp_sh = 3'd0;
    resp_f = 8'h04; resp_flg = 4'b0000;
    instr = {4'd1, 2'd1, 2'd1, 2'd1, 3'd0, 3'd0};
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_done", {15'd0, done}, 16'd0);
    check_eq("mid_status", {12'd0, status}, 16'd0);
    check_eq("mid_result", {8'd0, result}, 16'd0);
    check_eq("mid_alu_a", {8'd0, alu_a}, 16'd0);
    for (int i = 0; i < 4; i++) check_reg("mid_rf", i[1:0], 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_done", {15'd0, done}, 16'd0);
    end
    check_eq("post_rst_status", {12'd0, status}, 16'd0);
    check_reg("post_rst_r1", 2'd1, 8'h00);

    // handshake on the very first edge after reset release
    @(posedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    issue(4'd1, 2'd2, 2'd0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 4'b0001, 4'b0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
